// File: rtl/risc5_bus_pkg.sv
// risc5_bus_pkg: shared FSM states, halfword phase constants and strobe-count width
package risc5_bus_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
   localparam logic PH_LO  = 1'b0;
   localparam logic PH_HI  = 1'b1;
   localparam int   WAIT_W = 4;
endpackage

// File: rtl/sram_strobe_timer.sv
// sram_strobe_timer: loads the strobe length, counts down, flags the final strobe cycle
module sram_strobe_timer
   import risc5_bus_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [WAIT_W-1:0] i_wait,
   output logic              o_last
);
   logic [WAIT_W-1:0] r_cnt;
   always_ff @(posedge clk)
      if (rst) r_cnt <= '0;
      else if (i_load) r_cnt <= i_wait;
      else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_last = (r_cnt == WAIT_W'(1));
endmodule

// File: rtl/risc5_sram_responder.sv
// risc5_sram_responder: serves RISC5 word/byte bus accesses from a 16-bit async SRAM
module risc5_sram_responder
   import risc5_bus_pkg::*;
#(
   parameter int SRAM_AW = 19,
   parameter int WAIT    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic               req_we,
   input  logic [23:0]        adr,
   input  logic               ben,
   input  logic [31:0]        outbus,
   input  logic               rd,
   input  logic               wr,
   output logic [31:0]        inbus,
   output logic               stallX,
   output logic [SRAM_AW-1:0] sram_a,
   output logic [15:0]        sram_d_o,
   input  logic [15:0]        sram_d_i,
   output logic               sram_d_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);
   state_t r_state, w_next;
   logic   r_ph, r_we, r_ben;
   logic   w_start, w_ph, w_we, w_ben, w_more, w_act, w_strobe, w_last, w_unused;
   // The IDLE cycle that sees req doubles as the first SETUP, so no cycle is lost to decode.
   assign w_start  = (r_state == IDLE) & req;
   assign w_ph     = (r_state == IDLE) ? (ben ? adr[1] : PH_LO) : r_ph;
   assign w_we     = (r_state == IDLE) ? req_we : r_we;
   assign w_ben    = (r_state == IDLE) ? ben : r_ben;
   assign w_more   = ~w_ben & (w_ph == PH_LO);
   assign w_act    = ~rst & (w_start | (r_state inside {SETUP, STROBE, HOLD}));
   assign w_strobe = w_act & (r_state == STROBE);
   assign w_unused = ^adr[23:SRAM_AW+1];
   sram_strobe_timer u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_start | (r_state == SETUP)),
      .i_wait (WAIT_W'(WAIT)),
      .o_last (w_last)
   );
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = req ? STROBE : IDLE;
         SETUP:   w_next = STROBE;
         STROBE:  w_next = !w_last ? STROBE : r_we ? HOLD : w_more ? SETUP : DONE;
         HOLD:    w_next = w_more ? SETUP : DONE;
         DONE:    w_next = (rd | wr | ~req) ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_state <= IDLE;
         r_ph    <= PH_LO;
         r_we    <= 1'b0;
         r_ben   <= 1'b0;
         inbus   <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_ph  <= w_ph;
            r_we  <= req_we;
            r_ben <= ben;
         end else if (w_next == SETUP) r_ph <= PH_HI;
         if ((r_state == STROBE) & w_last & ~r_we) begin
            if (r_ph == PH_HI) inbus[31:16] <= sram_d_i;
            else inbus[15:0] <= sram_d_i;
         end
      end
   // Byte reads enable both lanes; the CPU picks the byte.
   assign stallX    = req & (r_state != DONE) & ~rst;
   assign sram_ce_n = ~w_act;
   assign sram_oe_n = ~(w_strobe & ~w_we);
   assign sram_we_n = ~(w_strobe & w_we);
   assign sram_d_oe = w_act & w_we;
   assign sram_ub_n = ~w_act | (w_we & w_ben & ~adr[0]);
   assign sram_lb_n = ~w_act | (w_we & w_ben & adr[0]);
   assign sram_a    = w_act ? {adr[SRAM_AW:2], w_ph} : '0;
   assign sram_d_o  = (w_ph == PH_HI) ? outbus[31:16] : outbus[15:0];
endmodule
